// File: rtl/segre_mem_arbiter_if.sv
// rtl/segre_mem_arbiter_if.sv - requester and main-memory bundle of the SEGRE memory arbiter
// master is the arbiter view; slave is the requesters/memory view.
interface segre_mem_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]        req_i;
    logic [NUM_CH-1:0]        we_i;
    logic [NUM_CH*ADDR_W-1:0] addr_i;
    logic [NUM_CH*DATA_W-1:0] wdata_i;
    logic [NUM_CH-1:0]        gnt_o;
    logic [NUM_CH-1:0]        rvalid_o;
    logic [DATA_W-1:0]        rdata_o;
    logic                     busy_o;
    logic [SEL_W-1:0]         sel_o;

    logic                     mem_req_o;
    logic                     mem_we_o;
    logic [ADDR_W-1:0]        mem_addr_o;
    logic [DATA_W-1:0]        mem_wdata_o;
    logic                     mem_ready_i;
    logic                     mem_rvalid_i;
    logic [DATA_W-1:0]        mem_rdata_i;

    modport master (
        input  req_i, we_i, addr_i, wdata_i, mem_ready_i, mem_rvalid_i, mem_rdata_i,
        output gnt_o, rvalid_o, rdata_o, busy_o, sel_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport slave (
        output req_i, we_i, addr_i, wdata_i, mem_ready_i, mem_rvalid_i, mem_rdata_i,
        input  gnt_o, rvalid_o, rdata_o, busy_o, sel_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/segre_mem_arbiter.sv
// rtl/segre_mem_arbiter.sv - N-channel single-outstanding main-memory arbiter (IDLE/REQ/WAIT)
// Optional SEGRE_ARB_RR_EN: round-robin arbitration; otherwise fixed priority, lowest index wins.
module segre_mem_arbiter #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk_i,
    input  logic               rsn_i,
    segre_mem_arbiter_if.master bus
);
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
`ifdef SEGRE_ARB_RR_EN
    logic [SEL_W-1:0]    ptr_q, ptr_d;
`endif

    logic                any_req;
    logic                arb_en;
    logic                take;
    logic                resp;
    logic [SEL_W-1:0]    win;

    always_comb begin
        any_req = |bus.req_i;
        win     = '0;
`ifdef SEGRE_ARB_RR_EN
        // Walk backwards so the channel closest after the last winner is assigned last.
        for (int k = NUM_CH; k >= 1; k--) begin
            if (bus.req_i[(int'(ptr_q) + k) % NUM_CH]) begin
                win = SEL_W'((int'(ptr_q) + k) % NUM_CH);
            end
        end
`else
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (bus.req_i[i]) begin
                win = SEL_W'(i);
            end
        end
`endif
    end

    // Re-arbitration on the completion cycle removes the IDLE bubble between transactions.
    assign arb_en = (state_q == IDLE) || ((state_q == WAIT) && bus.mem_rvalid_i);
    assign take   = arb_en && any_req;
    assign resp   = (state_q == WAIT) && bus.mem_rvalid_i;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef SEGRE_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: state_d = IDLE;
            REQ: begin
                if (bus.mem_ready_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (take) begin
            state_d = REQ;
            sel_d   = win;
            we_d    = bus.we_i[win];
            addr_d  = bus.addr_i[int'(win)*ADDR_W +: ADDR_W];
            wdata_d = bus.wdata_i[int'(win)*DATA_W +: DATA_W];
`ifdef SEGRE_ARB_RR_EN
            ptr_d   = win;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef SEGRE_ARB_RR_EN
            ptr_q   <= SEL_W'(NUM_CH - 1);
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef SEGRE_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    // Grant is combinational from req_i, so it must be gated by reset explicitly.
    assign bus.gnt_o       = (take && rsn_i) ? (NUM_CH'(1) << win) : '0;
    assign bus.rvalid_o    = resp ? (NUM_CH'(1) << sel_q) : '0;
    assign bus.rdata_o     = resp ? bus.mem_rdata_i : '0;
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.sel_o       = sel_q;
    assign bus.mem_req_o   = (state_q == REQ);
    assign bus.mem_we_o    = we_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// tb/tb_segre_mem_arbiter.sv - directed bench for segre_mem_arbiter (2- and 4-channel instances)
module tb_segre_mem_arbiter;
    logic clk_i = 1'b0;
    logic rsn_i = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   e2 [3];
    int   e4 [5];

    always #5 clk_i = ~clk_i;

    segre_mem_arbiter_if #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32)) bus0 ();
    segre_mem_arbiter_if #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32)) bus1 ();

    segre_mem_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32)) u_dut2 (
        .clk_i (clk_i),
        .rsn_i (rsn_i),
        .bus   (bus0.master)
    );

    segre_mem_arbiter #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32)) u_dut4 (
        .clk_i (clk_i),
        .rsn_i (rsn_i),
        .bus   (bus1.master)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
`ifdef SEGRE_ARB_RR_EN
        e2 = '{0, 1, 0};
        e4 = '{0, 1, 2, 3, 0};
`else
        e2 = '{0, 0, 0};
        e4 = '{0, 0, 0, 0, 0};
`endif
        bus0.req_i = '0; bus0.we_i = '0; bus0.addr_i = '0; bus0.wdata_i = '0;
        bus0.mem_ready_i = 1'b0; bus0.mem_rvalid_i = 1'b0; bus0.mem_rdata_i = '0;
        bus1.req_i = '0; bus1.we_i = '0; bus1.addr_i = '0; bus1.wdata_i = '0;
        bus1.mem_ready_i = 1'b0; bus1.mem_rvalid_i = 1'b0; bus1.mem_rdata_i = '0;

        // Reset state, with a request and a stray completion pending
        bus0.req_i = 2'b11;
        bus0.mem_rvalid_i = 1'b1;
        #3;
        chk("rst_gnt", bus0.gnt_o, 0);
        chk("rst_busy", bus0.busy_o, 0);
        chk("rst_mem_req", bus0.mem_req_o, 0);
        chk("rst_sel", bus0.sel_o, 0);
        chk("rst_rvalid", bus0.rvalid_o, 0);
        chk("rst_addr", bus0.mem_addr_o, 0);
        bus0.req_i = '0;
        bus0.mem_rvalid_i = 1'b0;
        #4;
        rsn_i = 1'b1;
        tick();

        // Single read on channel 1
        bus0.req_i  = 2'b10;
        bus0.we_i   = 2'b00;
        bus0.addr_i = {32'h0000_0100, 32'h0000_0555};
        #1;
        chk("t1_gnt", bus0.gnt_o, 2'b10);
        chk("t1_busy_idle", bus0.busy_o, 0);
        tick();
        bus0.req_i = '0;
        bus0.mem_ready_i = 1'b1;
        #1;
        chk("t1_mem_req", bus0.mem_req_o, 1);
        chk("t1_mem_addr", bus0.mem_addr_o, 32'h100);
        chk("t1_mem_we", bus0.mem_we_o, 0);
        chk("t1_sel", bus0.sel_o, 1);
        chk("t1_busy", bus0.busy_o, 1);
        tick();
        bus0.mem_ready_i = 1'b0;
        bus0.mem_rvalid_i = 1'b1;
        bus0.mem_rdata_i = 32'hDEAD;
        #1;
        chk("t1_wait_req", bus0.mem_req_o, 0);
        chk("t1_rvalid", bus0.rvalid_o, 2'b10);
        chk("t1_rdata", bus0.rdata_o, 32'hDEAD);
        tick();
        bus0.mem_rvalid_i = 1'b0;
        #1;
        chk("t1_idle_busy", bus0.busy_o, 0);
        chk("t1_idle_rdata", bus0.rdata_o, 0);

        // Write on channel 0 with a 5-cycle stall, then back-to-back channel 1
        bus0.req_i   = 2'b01;
        bus0.we_i    = 2'b01;
        bus0.addr_i  = {32'h0000_0100, 32'h0000_0200};
        bus0.wdata_i = {32'h0, 32'h0000_CAFE};
        #1;
        chk("t2_gnt", bus0.gnt_o, 2'b01);
        tick();
        bus0.req_i  = 2'b10;
        bus0.addr_i = {32'h0000_0100, 32'h0000_0777};
        for (int i = 0; i < 5; i++) begin
            bus0.mem_rvalid_i = (i == 2);
            #1;
            chk("t2_stall_req", bus0.mem_req_o, 1);
            chk("t2_stall_addr", bus0.mem_addr_o, 32'h200);
            chk("t2_stall_we", bus0.mem_we_o, 1);
            chk("t2_stall_wdata", bus0.mem_wdata_o, 32'hCAFE);
            chk("t2_stall_gnt", bus0.gnt_o, 0);
            chk("t2_stall_rvalid", bus0.rvalid_o, 0);
            tick();
        end
        bus0.mem_rvalid_i = 1'b0;
        bus0.mem_ready_i = 1'b1;
        #1;
        chk("t2_ready_req", bus0.mem_req_o, 1);
        tick();
        bus0.mem_ready_i = 1'b0;
        #1;
        chk("t2_wait_req", bus0.mem_req_o, 0);
        chk("t2_wait_busy", bus0.busy_o, 1);
        bus0.mem_rvalid_i = 1'b1;
        bus0.mem_rdata_i = 32'h1234;
        #1;
        chk("t2_rvalid", bus0.rvalid_o, 2'b01);
        chk("t2_rdata", bus0.rdata_o, 32'h1234);
        chk("t2_b2b_gnt", bus0.gnt_o, 2'b10);
        tick();
        bus0.mem_rvalid_i = 1'b0;
        bus0.req_i = '0;
        #1;
        chk("t2_b2b_req", bus0.mem_req_o, 1);
        chk("t2_b2b_sel", bus0.sel_o, 1);
        chk("t2_b2b_addr", bus0.mem_addr_o, 32'h100);
        chk("t2_b2b_we", bus0.mem_we_o, 0);
        bus0.mem_ready_i = 1'b1;
        tick();
        bus0.mem_ready_i = 1'b0;
        bus0.mem_rvalid_i = 1'b1;
        bus0.mem_rdata_i = 32'hBEEF;
        #1;
        chk("t2_b2b_rvalid", bus0.rvalid_o, 2'b10);
        chk("t2_b2b_rdata", bus0.rdata_o, 32'hBEEF);
        chk("t2_b2b_gnt_none", bus0.gnt_o, 0);
        tick();
        bus0.mem_rvalid_i = 1'b0;
        #1;
        chk("t2_idle_busy", bus0.busy_o, 0);
        bus0.mem_rvalid_i = 1'b1;
        bus0.mem_rdata_i = 32'h5555;
        #1;
        chk("stray_rvalid", bus0.rvalid_o, 0);
        chk("stray_rdata", bus0.rdata_o, 0);
        bus0.mem_rvalid_i = 1'b0;

        // Both channels requesting continuously
        bus0.we_i  = 2'b00;
        bus0.req_i = 2'b11;
        #1;
        chk("t3_gnt_first", bus0.gnt_o, 64'(1) << e2[0]);
        for (int i = 0; i < 3; i++) begin
            tick();
            bus0.mem_rvalid_i = 1'b0;
            #1;
            chk("t3_mem_req", bus0.mem_req_o, 1);
            chk("t3_sel", bus0.sel_o, e2[i]);
            bus0.mem_ready_i = 1'b1;
            tick();
            bus0.mem_ready_i = 1'b0;
            bus0.mem_rvalid_i = 1'b1;
            if (i == 2) bus0.req_i = '0;
            #1;
            chk("t3_rvalid", bus0.rvalid_o, 64'(1) << e2[i]);
            if (i < 2) chk("t3_gnt_next", bus0.gnt_o, 64'(1) << e2[i+1]);
            else       chk("t3_gnt_last", bus0.gnt_o, 0);
        end
        tick();
        bus0.mem_rvalid_i = 1'b0;
        #1;
        chk("t3_idle_busy", bus0.busy_o, 0);

        // Reset while waiting for memory drops the transaction
        bus0.req_i  = 2'b01;
        bus0.addr_i = {32'h0, 32'h0000_0300};
        tick();
        bus0.req_i = '0;
        bus0.mem_ready_i = 1'b1;
        tick();
        bus0.mem_ready_i = 1'b0;
        #1;
        chk("t4_wait_busy", bus0.busy_o, 1);
        rsn_i = 1'b0;
        bus0.req_i = 2'b01;
        #1;
        chk("t4_rst_busy", bus0.busy_o, 0);
        chk("t4_rst_mem_req", bus0.mem_req_o, 0);
        chk("t4_rst_addr", bus0.mem_addr_o, 0);
        chk("t4_rst_sel", bus0.sel_o, 0);
        chk("t4_rst_gnt", bus0.gnt_o, 0);
        bus0.req_i = '0;
        rsn_i = 1'b1;
        tick();
        bus0.mem_rvalid_i = 1'b1;
        bus0.mem_rdata_i = 32'hAAAA;
        #1;
        chk("t4_stray_rvalid", bus0.rvalid_o, 0);
        chk("t4_stray_rdata", bus0.rdata_o, 0);
        chk("t4_stray_busy", bus0.busy_o, 0);
        bus0.mem_rvalid_i = 1'b0;

        // Four channels requesting continuously
        bus1.req_i  = 4'b1111;
        bus1.addr_i = {32'h4000, 32'h3000, 32'h2000, 32'h1000};
        #1;
        chk("t5_gnt_first", bus1.gnt_o, 64'(1) << e4[0]);
        for (int i = 0; i < 5; i++) begin
            tick();
            bus1.mem_rvalid_i = 1'b0;
            #1;
            chk("t5_sel", bus1.sel_o, e4[i]);
            chk("t5_addr", bus1.mem_addr_o, 32'h1000 * (e4[i] + 1));
            bus1.mem_ready_i = 1'b1;
            tick();
            bus1.mem_ready_i = 1'b0;
            bus1.mem_rvalid_i = 1'b1;
            if (i == 4) bus1.req_i = '0;
            #1;
            chk("t5_rvalid", bus1.rvalid_o, 64'(1) << e4[i]);
            if (i < 4) chk("t5_gnt_next", bus1.gnt_o, 64'(1) << e4[i+1]);
            else       chk("t5_gnt_last", bus1.gnt_o, 0);
        end
        tick();
        bus1.mem_rvalid_i = 1'b0;
        #1;
        chk("t5_idle_busy", bus1.busy_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/segre_mem_arbiter.md
SEGRE_MEM_ARBITER -- requirements
Module: segre_mem_arbiter

Interface
REQ-001 Parameter NUM_CH, default 2, number of requesters; channel 0 is the instruction cache, channel 1 the data cache; legal range 1..8.
REQ-002 Parameter ADDR_W, default 32, memory address width.
REQ-003 Parameter DATA_W, default 32, memory data width.
REQ-004 Clock and reset SHALL be: one clock, clk_i; reset rsn_i is asynchronous and active-low.
REQ-005 clk_i  in  1  clock; all state updates on rising edge.
REQ-006 rsn_i  in  1  asynchronous active-low reset.
REQ-007 req_i  in  NUM_CH  per-channel request, held by requester until its gnt_o bit.
REQ-008 we_i  in  NUM_CH  per-channel write enable, 0 read, 1 write.
REQ-009 addr_i  in  NUM_CH*ADDR_W  per-channel address, channel k in bits [k*ADDR_W +: ADDR_W].
REQ-010 wdata_i  in  NUM_CH*DATA_W  per-channel write data, same packing.
REQ-011 gnt_o  out  NUM_CH  one-hot grant, one-cycle pulse.
REQ-012 rvalid_o  out  NUM_CH  one-hot response valid, one-cycle pulse.
REQ-013 rdata_o  out  DATA_W  response data, shared by all channels.
REQ-014 busy_o  out  1  transaction owned by a channel.
REQ-015 sel_o  out  max(1,$clog2(NUM_CH))  owner index, valid while busy_o.
REQ-016 mem_req_o / mem_we_o / mem_addr_o / mem_wdata_o  out  1/1/ADDR_W/DATA_W  main-memory request.
REQ-017 mem_ready_i  in  1  memory accepts the request this cycle.
REQ-018 mem_rvalid_i / mem_rdata_i  in  1/DATA_W  memory completion (reads and writes), read data.

Function
REQ-019 FSM states IDLE, REQ, WAIT; one transaction outstanding at most.
REQ-020 Arbitration: in IDLE, or in WAIT on the mem_rvalid_i cycle, if any req_i is set, pick a winner w; gnt_o[w]=1 combinationally that cycle; latch w, we_i[w], addr_i[w], wdata_i[w]; next state REQ.
REQ-021 In IDLE with no req_i: gnt_o=0, stay IDLE.
REQ-022 REQ: mem_req_o=1 with latched fields, held stable until mem_ready_i=1; then go to WAIT.
REQ-023 WAIT: mem_req_o=0; on mem_rvalid_i, rvalid_o[sel_o]=1 and rdata_o=mem_rdata_i the same cycle (zero latency); then REQ if re-arbitration won (REQ-020), else IDLE.
REQ-024 Back-to-back: no IDLE bubble between transactions; new mem_req_o is asserted the cycle after the previous mem_rvalid_i.
REQ-025 mem_rvalid_i outside WAIT SHALL be ignored: rvalid_o=0.
REQ-026 req_i changes while busy SHALL NOT alter latched fields.
REQ-027 busy_o=1 in REQ and WAIT; rdata_o=0 whenever rvalid_o=0.
REQ-028 NUM_CH=1: arbitration is trivial; sel_o is constant 0.

Reset
REQ-029 rsn_i low SHALL immediately force IDLE with gnt_o, rvalid_o, busy_o, sel_o, mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o all 0, and reset the round-robin pointer to NUM_CH-1; an in-flight transaction is dropped, not replayed.

Configuration
REQ-030 SEGRE_ARB_RR_EN defined: round-robin; search starts at (last winner+1) mod NUM_CH, pointer updated on each grant; undefined: fixed priority, lowest index wins (IC over DC), no pointer register.

Verification
REQ-031 NUM_CH=2, req_i=2'b10, addr ch1=0x100, read -> gnt_o=2'b10 same cycle; mem_req_o=1, mem_addr_o=0x100 next cycle; mem_rvalid_i with 0xDEAD -> rvalid_o=2'b10, rdata_o=0xDEAD.
REQ-032 req_i=2'b11 held, ch0 re-requesting after grant -> RR: grant order ch0,ch1,ch0; fixed: ch0,ch0,ch0.
REQ-033 mem_ready_i low 5 cycles in REQ -> mem_req_o and mem_addr_o stable for 5 cycles; WAIT entered the cycle after mem_ready_i.
REQ-034 Pending req_i=2'b01 on mem_rvalid_i cycle -> gnt_o=2'b01 that cycle; mem_req_o=1 next cycle, no IDLE cycle.
REQ-035 rsn_i low during WAIT -> all outputs 0 immediately; after release, stray mem_rvalid_i -> rvalid_o=0.
REQ-036 NUM_CH=4, SEGRE_ARB_RR_EN, req_i=4'b1111 held -> grants 0,1,2,3,0 on successive transactions.
